// File: rtl/register_file_16x8_pkg.sv
// Shared sizes, types and reset value for the 16x8 register file.
package register_file_16x8_pkg;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] rf_data_t;
    typedef logic [ADDR_W-1:0] rf_addr_t;

    localparam rf_data_t RF_RESET_VAL = 8'h00;
endpackage

// File: rtl/register_file_16x8_if.sv
// Datapath-side bus of the register file: one write port, two read ports.
interface register_file_16x8_if;
    import register_file_16x8_pkg::*;

    // No handshake: a write lands on every rising edge and reads are combinational.
    rf_data_t replaceData;
    rf_addr_t replaceSel;
    rf_addr_t A_sel;
    rf_addr_t B_sel;
    rf_data_t A;
    rf_data_t B;

    modport master (
        output replaceData, replaceSel, A_sel, B_sel,
        input  A, B
    );

    modport slave (
        input  replaceData, replaceSel, A_sel, B_sel,
        output A, B
    );
endinterface

// File: rtl/register_file_16x8_read_port.sv
// Combinational NUM_REGS:1 read mux; one instance per operand bus.
module regfile_read_port
    import register_file_16x8_pkg::*;
(
    input  rf_data_t i_regs [NUM_REGS],
    input  rf_addr_t i_sel,
    output rf_data_t o_data
);
    always_comb begin
        o_data = RF_RESET_VAL;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_sel == rf_addr_t'(i)) begin
                o_data = i_regs[i];
            end
        end
    end
endmodule

// File: rtl/register_file_16x8.sv
// 16x8 register file: unconditional write every edge, two independent async read ports.
module register_file_16x8
    import register_file_16x8_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    register_file_16x8_if.slave   bus
);
    rf_data_t r_regs [NUM_REGS];
    rf_data_t w_a;
    rf_data_t w_b;

    // Reset wins over the write on a shared edge; no bypass, so a write shows after its edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= RF_RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.replaceSel == rf_addr_t'(i)) begin
                    r_regs[i] <= bus.replaceData;
                end
            end
        end
    end

    regfile_read_port u_read_a (
        .i_regs (r_regs),
        .i_sel  (bus.A_sel),
        .o_data (w_a)
    );

    regfile_read_port u_read_b (
        .i_regs (r_regs),
        .i_sel  (bus.B_sel),
        .o_data (w_b)
    );

    assign bus.A = w_a;
    assign bus.B = w_b;
endmodule

// File: tb/tb_register_file_16x8.sv
// Bench for register_file_16x8: directed scenarios plus random traffic against an array model.
`timescale 1ns/1ps
module tb_register_file_16x8;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    register_file_16x8_if rf_bus ();

    register_file_16x8 dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_bus)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: 16 plain bytes; reset clears, every edge stores data at the write index.
    logic [7:0] ref_regs [16];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) ref_regs[k] = 8'h00;
        end else begin
            ref_regs[rf_bus.replaceSel] = rf_bus.replaceData;
        end
    end

    task automatic drive(input logic [7:0] d, input logic [3:0] ws,
                         input logic [3:0] as, input logic [3:0] bs);
        rf_bus.replaceData = d;
        rf_bus.replaceSel  = ws;
        rf_bus.A_sel       = as;
        rf_bus.B_sel       = bs;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b0; drive(8'h5A, 4'd0, 4'd0, 4'd15);
        @(negedge clk); drive(8'hA5, 4'd15, 4'd0, 4'd15);
        @(posedge clk); #1;
        n_cmp++;
        if (rf_bus.A !== 8'h5A || rf_bus.B !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_prefill: A=%h B=%h expected A=5a B=a5", rf_bus.A, rf_bus.B);
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rf_bus.A !== 8'h00 || rf_bus.B !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_immediate: A=%h B=%h expected 00 00", rf_bus.A, rf_bus.B);
        end
        for (int i = 0; i < 16; i++) begin
            rf_bus.A_sel = 4'(i);
            rf_bus.B_sel = 4'(15 - i);
            #1;
            n_cmp++;
            if (rf_bus.A !== 8'h00 || rf_bus.B !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_all_regs[%0d]: A=%h B=%h expected 00 00", i, rf_bus.A, rf_bus.B);
            end
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed_writes();
        logic [7:0] exp_a [3];
        logic [7:0] exp_b [3];
        logic [3:0] asel  [3];
        logic [3:0] bsel  [3];
        logic [7:0] dat   [3];
        dat  = '{8'hAA, 8'hBB, 8'hCC};
        asel = '{4'd0, 4'd1, 4'd2};
        bsel = '{4'd0, 4'd0, 4'd1};
        exp_a = '{8'hAA, 8'hBB, 8'hCC};
        exp_b = '{8'hAA, 8'hAA, 8'hBB};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(dat[i], 4'(i), asel[i], bsel[i]);
            @(posedge clk); #1;
            n_cmp++;
            if (rf_bus.A !== exp_a[i] || rf_bus.B !== exp_b[i]) begin
                n_fail++;
                $display("FAIL directed_write[%0d]: A=%h B=%h expected A=%h B=%h",
                         i, rf_bus.A, rf_bus.B, exp_a[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_read_during_write();
        @(negedge clk); drive(8'h11, 4'd5, 4'd5, 4'd5);
        @(negedge clk); rf_bus.replaceData = 8'h22;
        #1;
        n_cmp++;
        if (rf_bus.A !== 8'h11 || rf_bus.B !== 8'h11) begin
            n_fail++;
            $display("FAIL rdw_before_edge: A=%h B=%h expected 11 11", rf_bus.A, rf_bus.B);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rf_bus.A !== 8'h22 || rf_bus.B !== 8'h22) begin
            n_fail++;
            $display("FAIL rdw_after_edge: A=%h B=%h expected 22 22", rf_bus.A, rf_bus.B);
        end
    endtask

    task automatic test_sweep_and_reset();
        logic [7:0] ea;
        logic [7:0] eb;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); drive(8'(i * 16 + 15), 4'(i), 4'(i), 4'(i));
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rf_bus.A_sel = 4'(i);
            rf_bus.B_sel = 4'(15 - i);
            #1;
            ea = (i >= 8) ? 8'h00 : 8'(i * 16 + 15);
            eb = (i >= 8) ? 8'h00 : 8'((15 - i) * 16 + 15);
            n_cmp++;
            if (rf_bus.A !== ea || rf_bus.B !== eb) begin
                n_fail++;
                $display("FAIL sweep[%0d]: A=%h B=%h expected A=%h B=%h", i, rf_bus.A, rf_bus.B, ea, eb);
            end
            if (i == 7) begin
                #1 rst = 1'b1;
                #1;
                n_cmp++;
                if (rf_bus.A !== 8'h00 || rf_bus.B !== 8'h00) begin
                    n_fail++;
                    $display("FAIL sweep_reset_immediate: A=%h B=%h expected 00 00", rf_bus.A, rf_bus.B);
                end
            end
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] as;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            as = 4'($urandom_range(0, 15));
            drive(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), as,
                  ($urandom_range(0, 9) == 0) ? as : 4'($urandom_range(0, 15)));
            #1;
            n_cmp++;
            if (rf_bus.A !== ref_regs[rf_bus.A_sel] || rf_bus.B !== ref_regs[rf_bus.B_sel]) begin
                n_fail++;
                $display("FAIL random_pre_edge[%0d]: A=%h B=%h expected A=%h B=%h", n,
                         rf_bus.A, rf_bus.B, ref_regs[rf_bus.A_sel], ref_regs[rf_bus.B_sel]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (rf_bus.A !== ref_regs[rf_bus.A_sel] || rf_bus.B !== ref_regs[rf_bus.B_sel]) begin
                n_fail++;
                $display("FAIL random_post_edge[%0d]: A=%h B=%h expected A=%h B=%h", n,
                         rf_bus.A, rf_bus.B, ref_regs[rf_bus.A_sel], ref_regs[rf_bus.B_sel]);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        drive(8'h00, 4'd0, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        test_reset();
        test_directed_writes();
        test_read_during_write();
        test_sweep_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
